// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: front-end freeze/bubble/flush and SRAM wait FSM.
// Ports: clk, rst (sync high), hazard/branch/mem inputs, control + perf counters.
module pipeline_stall_controller #(
  parameter int unsigned SRAM_LATENCY = 6,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_Detected,
  input  logic             branch_taken,
  input  logic             mem_R_EN,
  input  logic             mem_W_EN,
  output logic             freeze_front,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_ready,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The RUN cycle already counts as the first freeze cycle, so the
  // down-counter covers the remaining SRAM_LATENCY-1 WAIT cycles.
  localparam logic [3:0] WCNT_INIT =
    (SRAM_LATENCY > 1) ? 4'(SRAM_LATENCY - 2) : 4'd0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic             mem_req;

  assign mem_req = mem_R_EN | mem_W_EN;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    freeze_all = 1'b0;
    mem_ready  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_req) begin
          freeze_all = 1'b1;
          if (SRAM_LATENCY == 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_INIT;
          end
        end
      end
      S_WAIT: begin
        freeze_all = 1'b1;
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Same instruction still sits in MEM: ignore its request.
        mem_ready = 1'b1;
        state_d   = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = 4'd0;
      end
    endcase
    // Reset abandons any access and silences every output.
    if (rst) begin
      state_d    = S_RUN;
      wcnt_d     = 4'd0;
      freeze_all = 1'b0;
      mem_ready  = 1'b0;
    end
  end

  // freeze_all already holds every stage, so front-end actions are
  // suppressed to avoid a spurious bubble or a lost flush.
  always_comb begin
    freeze_front = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (!rst && !freeze_all) begin
      freeze_front = hazard_Detected;
      bubble_id_ex = hazard_Detected;
      flush_if_id  = branch_taken & ~hazard_Detected;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             en
  );
    if (en && (cnt != CNT_MAX)) begin
      return cnt + 1'b1;
    end
    return cnt;
  endfunction

  always_comb begin
    hz_cnt_d = sat_inc(hz_cnt_q, bubble_id_ex);
    ms_cnt_d = sat_inc(ms_cnt_q, freeze_all);
    fl_cnt_d = sat_inc(fl_cnt_q, flush_if_id);
    if (rst) begin
      hz_cnt_d = '0;
      ms_cnt_d = '0;
      fl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    wcnt_q   <= wcnt_d;
    hz_cnt_q <= hz_cnt_d;
    ms_cnt_q <= ms_cnt_d;
    fl_cnt_q <= fl_cnt_d;
  end

  assign hazard_stall_cnt = hz_cnt_q;
  assign mem_stall_cnt    = ms_cnt_q;
  assign flush_cnt        = fl_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: three configurations checked
// against a cycle-count model, a vector table and corner sequences.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_Detected, branch_taken, mem_R_EN, mem_W_EN;
  logic ff [3];
  logic bub [3];
  logic fl [3];
  logic fa [3];
  logic mr [3];
  logic [15:0] hc0, mc0, fc0, hc1, mc1, fc1;
  logic [3:0]  hc2, mc2, fc2;

  pipeline_stall_controller #(.SRAM_LATENCY(6), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected),
    .branch_taken(branch_taken), .mem_R_EN(mem_R_EN), .mem_W_EN(mem_W_EN),
    .freeze_front(ff[0]), .bubble_id_ex(bub[0]), .flush_if_id(fl[0]),
    .freeze_all(fa[0]), .mem_ready(mr[0]),
    .hazard_stall_cnt(hc0), .mem_stall_cnt(mc0), .flush_cnt(fc0));

  pipeline_stall_controller #(.SRAM_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected),
    .branch_taken(branch_taken), .mem_R_EN(mem_R_EN), .mem_W_EN(mem_W_EN),
    .freeze_front(ff[1]), .bubble_id_ex(bub[1]), .flush_if_id(fl[1]),
    .freeze_all(fa[1]), .mem_ready(mr[1]),
    .hazard_stall_cnt(hc1), .mem_stall_cnt(mc1), .flush_cnt(fc1));

  pipeline_stall_controller #(.SRAM_LATENCY(6), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected),
    .branch_taken(branch_taken), .mem_R_EN(mem_R_EN), .mem_W_EN(mem_W_EN),
    .freeze_front(ff[2]), .bubble_id_ex(bub[2]), .flush_if_id(fl[2]),
    .freeze_all(fa[2]), .mem_ready(mr[2]),
    .hazard_stall_cnt(hc2), .mem_stall_cnt(mc2), .flush_cnt(fc2));

  int ncmp = 0;
  int nfail = 0;

  // Model: cycles of freeze still owed, and a pending completion pulse.
  int lat  [3] = '{6, 1, 6};
  int cmax [3] = '{65535, 65535, 15};
  int left [3] = '{0, 0, 0};
  bit owe  [3] = '{0, 0, 0};
  int mh   [3] = '{0, 0, 0};
  int mm   [3] = '{0, 0, 0};
  int mf   [3] = '{0, 0, 0};

  // Samples of the last checked cycle, for hand-written sequences.
  bit [4:0] s_o [3];
  int s_h [3];
  int s_m [3];
  int s_f [3];

  task automatic check(input string nm, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int sat(input int v, input bit en, input int mx);
    return (en && v < mx) ? v + 1 : v;
  endfunction

  task automatic step(input bit r, input bit hz, input bit br,
                      input bit rd, input bit wr, input bit chk);
    bit e_fa, e_mr, e_ff, e_fl;
    rst = r; hazard_Detected = hz; branch_taken = br;
    mem_R_EN = rd; mem_W_EN = wr;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e_fa = 0; e_mr = 0; e_ff = 0; e_fl = 0;
      if (!r) begin
        if (owe[k]) e_mr = 1;
        else if (left[k] > 0 || rd || wr) e_fa = 1;
        if (!e_fa) begin
          e_ff = hz;
          e_fl = br & ~hz;
        end
      end
      s_o[k] = {ff[k], bub[k], fl[k], fa[k], mr[k]};
      case (k)
        0: begin s_h[k] = hc0; s_m[k] = mc0; s_f[k] = fc0; end
        1: begin s_h[k] = hc1; s_m[k] = mc1; s_f[k] = fc1; end
        default: begin s_h[k] = hc2; s_m[k] = mc2; s_f[k] = fc2; end
      endcase
      if (chk) begin
        check($sformatf("ctl%0d", k), s_o[k], {e_ff, e_ff, e_fl, e_fa, e_mr});
        check($sformatf("hcnt%0d", k), s_h[k], mh[k]);
        check($sformatf("mcnt%0d", k), s_m[k], mm[k]);
        check($sformatf("fcnt%0d", k), s_f[k], mf[k]);
      end
      if (r) begin
        left[k] = 0; owe[k] = 0; mh[k] = 0; mm[k] = 0; mf[k] = 0;
      end else begin
        mh[k] = sat(mh[k], e_ff, cmax[k]);
        mm[k] = sat(mm[k], e_fa, cmax[k]);
        mf[k] = sat(mf[k], e_fl, cmax[k]);
        if (owe[k]) owe[k] = 0;
        else if (left[k] > 0) begin
          left[k]--;
          if (left[k] == 0) owe[k] = 1;
        end else if (rd || wr) begin
          left[k] = lat[k] - 1;
          if (left[k] == 0) owe[k] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    bit r, hz, br, rd, wr;
    bit [4:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // exp = {freeze_front, bubble, flush, freeze_all, mem_ready} of dut0
    tbl[0]  = '{1, 0, 0, 0, 0, 5'b00000};
    tbl[1]  = '{1, 0, 0, 0, 0, 5'b00000};
    tbl[2]  = '{0, 0, 0, 0, 0, 5'b00000};
    tbl[3]  = '{0, 1, 1, 0, 0, 5'b11000};
    tbl[4]  = '{0, 0, 1, 0, 0, 5'b00100};
    tbl[5]  = '{0, 0, 0, 1, 0, 5'b00010};
    tbl[6]  = '{0, 1, 0, 1, 0, 5'b00010};
    tbl[7]  = '{0, 0, 1, 1, 0, 5'b00010};
    tbl[8]  = '{0, 0, 0, 1, 0, 5'b00010};
    tbl[9]  = '{0, 0, 0, 1, 0, 5'b00010};
    tbl[10] = '{0, 0, 0, 1, 0, 5'b00010};
    tbl[11] = '{0, 0, 0, 1, 0, 5'b00001};
    tbl[12] = '{0, 0, 0, 0, 0, 5'b00000};

    rst = 1; hazard_Detected = 0; branch_taken = 0;
    mem_R_EN = 0; mem_W_EN = 0;
    step(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].hz, tbl[i].br, tbl[i].rd, tbl[i].wr, 1);
      check($sformatf("tbl%0d", i), s_o[0], tbl[i].exp);
    end
    step(0, 0, 0, 0, 0, 1);
    check("hz_cnt_after_tbl", s_h[0], 1);
    check("fl_cnt_after_tbl", s_f[0], 1);
    check("ms_cnt_after_tbl", s_m[0], 6);

    // Back-to-back memory instructions on the 1-cycle SRAM.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, i[0], 1);
      check($sformatf("b2b_fa%0d", i), s_o[1][1], (i % 2 == 0) ? 1 : 0);
      check($sformatf("b2b_mr%0d", i), s_o[1][0], (i % 2 == 1) ? 1 : 0);
    end

    // Reset during the third WAIT cycle drops the access.
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    check("rst_wait_out", s_o[0], 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_wait_nordy", s_o[0], 0);
    check("rst_wait_mcnt", s_m[0], 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_wait_nordy2", s_o[0], 0);

    // Counter saturation on the 4-bit instance.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("sat_hcnt4", s_h[2], 15);
    check("sat_hcnt16", s_h[0], 20);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
